digit_serial_adder_ctrl: RTL and testbench

Sequencer for the digit-serial adder datapath. It accepts a pair of W-bit parallel operands and a carry-in over a valid/ready handshake, then issues them to the adder one D-bit digit per cycle, least-significant digit first. It collects the returned sum digits into a W-bit result and presents the result and the final carry-out over a second valid/ready handshake. It sits between a parallel producer/consumer and the digit-serial adder, and owns all digit counting and carry-initialisation sequencing.

---
 rtl/digit_serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_digit_serial_adder_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial adder sequencer: accepts parallel operands, issues them LSD-first
// one digit per cycle, reassembles the returned sum digits and hands off the result.
module digit_serial_adder_ctrl #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         dsa_valid,
  output logic         dsa_first,
  output logic [D-1:0] dsa_a,
  output logic [D-1:0] dsa_b,
  output logic         dsa_cin,
  input  logic         dsa_sum_valid,
  input  logic [D-1:0] dsa_sum,
  input  logic         dsa_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int unsigned N  = W / D;
  localparam int unsigned CW = $clog2(N + 1);

  // Operand width must split into whole digits
  if ((W % D) != 0) begin : g_bad_width
    $fatal(1, "digit_serial_adder_ctrl: W must be a multiple of D");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] rx_cnt;
  logic          accept;
  logic          rx_beat;
  logic          rx_last;
  logic          issue_last;

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_d    = state;
    accept     = (state == IDLE) && in_valid && in_ready;
    rx_beat    = ((state == ISSUE) || (state == DRAIN)) && dsa_sum_valid &&
                 (rx_cnt < CW'(N));
    rx_last    = rx_beat && (rx_cnt == CW'(N - 1));
    issue_last = (state == ISSUE) && (issue_cnt == CW'(N - 1));
    case (state)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = (rx_last || (rx_cnt == CW'(N))) ? DONE : DRAIN;
      DRAIN:   if (rx_last) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Handshake flags follow the upcoming state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Issue path: digit 0 loads straight from the inputs, the rest shift out of the operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      issue_cnt <= '0;
      dsa_valid <= 1'b0;
      dsa_first <= 1'b0;
      dsa_cin   <= 1'b0;
      dsa_a     <= '0;
      dsa_b     <= '0;
    end else if (accept) begin
      a_sr      <= in_a >> D;
      b_sr      <= in_b >> D;
      issue_cnt <= '0;
      dsa_valid <= 1'b1;
      dsa_first <= 1'b1;
      dsa_cin   <= in_cin;
      dsa_a     <= in_a[D-1:0];
      dsa_b     <= in_b[D-1:0];
    end else if (state == ISSUE) begin
      issue_cnt <= issue_cnt + CW'(1);
      dsa_first <= 1'b0;
      dsa_cin   <= 1'b0;
      if (issue_last) begin
        dsa_valid <= 1'b0;
        dsa_a     <= '0;
        dsa_b     <= '0;
      end else begin
        dsa_a <= a_sr[D-1:0];
        dsa_b <= b_sr[D-1:0];
        a_sr  <= a_sr >> D;
        b_sr  <= b_sr >> D;
      end
    end
  end

  // Receive path: place each returned digit by rx_cnt; rx_cnt saturates at N
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      rx_cnt <= '0;
    end else if (rx_beat) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (rx_cnt == CW'(i)) out_sum[i*D +: D] <= dsa_sum;
      end
      rx_cnt <= rx_cnt + CW'(1);
      if (rx_last) out_cout <= dsa_cout;
    end
  end

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// Directed and randomised checks of the digit-serial adder sequencer against a
// behavioural adder model with selectable latency.
module tb_digit_serial_adder_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          dsa_valid;
  logic          dsa_first;
  logic [D-1:0]  dsa_a;
  logic [D-1:0]  dsa_b;
  logic          dsa_cin;
  logic          dsa_sum_valid;
  logic [D-1:0]  dsa_sum;
  logic          dsa_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;

  int checks = 0;
  int errors = 0;

  digit_serial_adder_ctrl #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dsa_valid(dsa_valid), .dsa_first(dsa_first),
    .dsa_a(dsa_a), .dsa_b(dsa_b), .dsa_cin(dsa_cin),
    .dsa_sum_valid(dsa_sum_valid), .dsa_sum(dsa_sum), .dsa_cout(dsa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  // Behavioural digit-serial adder: carry register plus a delay line tapped at lat
  int         lat = 1;
  logic [3:0] pipe_s [0:3];
  logic       pipe_c [0:3];
  logic       pipe_v [0:3];
  logic       carry_q;
  logic       inj_v = 1'b0;
  logic [3:0] inj_sum = 4'h0;
  logic       inj_cout = 1'b0;

  always @(posedge clk) begin
    logic       cin_eff;
    logic [4:0] r;
    cin_eff = dsa_first ? dsa_cin : carry_q;
    r = 5'(dsa_a) + 5'(dsa_b) + 5'(cin_eff);
    if (dsa_valid) carry_q <= r[4];
    pipe_v[0] <= dsa_valid;
    pipe_s[0] <= r[3:0];
    pipe_c[0] <= r[4];
    for (int i = 1; i < 4; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_s[i] <= pipe_s[i-1];
      pipe_c[i] <= pipe_c[i-1];
    end
  end

  assign dsa_sum_valid = inj_v | pipe_v[lat-1];
  assign dsa_sum       = inj_v ? inj_sum  : pipe_s[lat-1];
  assign dsa_cout      = inj_v ? inj_cout : pipe_c[lat-1];

  // Record issued digits away from the active edge
  logic [3:0] rec_a [$];
  logic [3:0] rec_b [$];
  logic       rec_first [$];
  logic       rec_cin [$];

  always @(negedge clk) begin
    if (!reset && dsa_valid) begin
      rec_a.push_back(dsa_a);
      rec_b.push_back(dsa_b);
      rec_first.push_back(dsa_first);
      rec_cin.push_back(dsa_cin);
    end
  end

  task automatic clear_rec();
    rec_a.delete();
    rec_b.delete();
    rec_first.delete();
    rec_cin.delete();
  endtask

  // Present operands and hold them until the controller takes them
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Wait for a result, sample it, then accept it after hold cycles
  task automatic get_result(input int hold, output logic [W-1:0] s, output logic c);
    out_ready = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%0b required 1", out_valid);
    end
    s = out_sum;
    c = out_cout;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || dsa_valid !== 1'b0 || dsa_first !== 1'b0 || dsa_cin !== 1'b0 ||
        out_valid !== 1'b0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%0b dv=%0b df=%0b dc=%0b ov=%0b oc=%0b required 1 0 0 0 0 0",
               in_ready, dsa_valid, dsa_first, dsa_cin, out_valid, out_cout);
    end
    checks++;
    if (dsa_a !== 4'h0 || dsa_b !== 4'h0 || out_sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h sum=%h required 0 0 0000", dsa_a, dsa_b, out_sum);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s;
    logic         c;
    logic [3:0]   ea [4];
    logic [3:0]   eb [4];
    bit           bad;
    ea[0] = 4'h4; ea[1] = 4'h3; ea[2] = 4'h2; ea[3] = 4'h1;
    eb[0] = 4'hF; eb[1] = 4'hF; eb[2] = 4'hF; eb[3] = 4'h0;
    lat = 1;
    clear_rec();
    send(16'h1234, 16'h0FFF, 1'b0);
    get_result(0, s, c);
    checks++;
    if ({c, s} !== 17'h02233) begin
      errors++;
      $display("FAIL basic_sum got %0b_%h required 0_2233", c, s);
    end
    checks++;
    if (rec_a.size() != 4) begin
      errors++;
      $display("FAIL basic_digit_count got %0d required 4", rec_a.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++)
        if (rec_a[i] !== ea[i] || rec_b[i] !== eb[i] || rec_first[i] !== (i == 0) || rec_cin[i] !== 1'b0)
          bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL basic_digits got a=%h%h%h%h b=%h%h%h%h first=%0b%0b%0b%0b required a=4321 b=FFF0 first=1000",
                 rec_a[0], rec_a[1], rec_a[2], rec_a[3], rec_b[0], rec_b[1], rec_b[2], rec_b[3],
                 rec_first[0], rec_first[1], rec_first[2], rec_first[3]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s;
    logic         c;
    lat = 1;
    send(16'hFFFF, 16'h0001, 1'b0);
    get_result(0, s, c);
    checks++;
    if ({c, s} !== 17'h10000) begin
      errors++;
      $display("FAIL overflow got %0b_%h required 1_0000", c, s);
    end
  endtask

  task automatic test_carry_in();
    logic [W-1:0] s;
    logic         c;
    lat = 1;
    clear_rec();
    send(16'h0000, 16'h0000, 1'b1);
    get_result(0, s, c);
    checks++;
    if ({c, s} !== 17'h00001) begin
      errors++;
      $display("FAIL carry_in_sum got %0b_%h required 0_0001", c, s);
    end
    checks++;
    if (rec_cin.size() != 4 || rec_cin[0] !== 1'b1 || rec_cin[1] !== 1'b0 ||
        rec_cin[2] !== 1'b0 || rec_cin[3] !== 1'b0) begin
      errors++;
      $display("FAIL carry_in_digits got n=%0d cin0=%0b required n=4 cin=1000", rec_cin.size(),
               (rec_cin.size() > 0) ? rec_cin[0] : 1'bx);
    end
  endtask

  task automatic test_back_to_back(input int l);
    logic [W-1:0] s0;
    logic         c0;
    logic [W-1:0] s;
    logic         c;
    bit           stable;
    lat = l;
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    s0 = out_sum;
    c0 = out_cout;
    checks++;
    if (out_valid !== 1'b1 || {c0, s0} !== 17'h03333) begin
      errors++;
      $display("FAIL bp_first_result lat=%0d got v=%0b %0b_%h required 1 0_3333", l, out_valid, c0, s0);
    end
    in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b1; in_valid = 1'b1;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (out_sum !== s0 || out_cout !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold lat=%0d got sum=%h v=%0b rdy=%0b required %h 1 0", l, out_sum, out_valid, in_ready, s0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_handoff lat=%0d got rdy=%0b v=%0b required 1 0", l, in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || dsa_valid !== 1'b1 || dsa_first !== 1'b1 || dsa_cin !== 1'b1 || dsa_a !== 4'h0) begin
      errors++;
      $display("FAIL bp_second_accept lat=%0d got rdy=%0b dv=%0b df=%0b dc=%0b a=%h required 0 1 1 1 0",
               l, in_ready, dsa_valid, dsa_first, dsa_cin, dsa_a);
    end
    get_result(0, s, c);
    checks++;
    if ({c, s} !== 17'h10001) begin
      errors++;
      $display("FAIL bp_second_result lat=%0d got %0b_%h required 1_0001", l, c, s);
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] s;
    logic         c;
    bit           quiet;
    lat = 3;
    send(16'h5555, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || dsa_valid !== 1'b0 || dsa_first !== 1'b0 || dsa_cin !== 1'b0 ||
        dsa_a !== 4'h0 || dsa_b !== 4'h0 || out_valid !== 1'b0 || out_sum !== 16'h0000 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got rdy=%0b dv=%0b a=%h b=%h ov=%0b sum=%h oc=%0b required 1 0 0 0 0 0000 0",
               in_ready, dsa_valid, dsa_a, dsa_b, out_valid, out_sum, out_cout);
    end
    @(negedge clk);
    reset = 1'b0;
    quiet = 1;
    repeat (5) begin
      @(negedge clk);
      if (out_sum !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || dsa_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL midop_late_digits got sum=%h ov=%0b rdy=%0b required 0000 0 1", out_sum, out_valid, in_ready);
    end
    send(16'h00FF, 16'h0001, 1'b0);
    get_result(0, s, c);
    checks++;
    if ({c, s} !== 17'h00100) begin
      errors++;
      $display("FAIL midop_next_op got %0b_%h required 0_0100", c, s);
    end
  endtask

  task automatic test_ignore_beats();
    lat = 1;
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    inj_sum = 4'hF; inj_cout = 1'b1; inj_v = 1'b1;
    repeat (2) @(negedge clk);
    inj_v = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h1010 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_in_done got v=%0b %0b_%h required 1 0_1010", out_valid, out_cout, out_sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    inj_v = 1'b1;
    repeat (2) @(negedge clk);
    inj_v = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h1010 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_in_idle got v=%0b rdy=%0b %0b_%h required 0 1 0_1010", out_valid, in_ready, out_cout, out_sum);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         c;
    logic [W:0]   exp;
    lat = 1;
    for (int n = 0; n < 1000; n++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      ci  = 1'($urandom_range(0, 1));
      exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
      send(a, b, ci);
      get_result(int'($urandom_range(0, 3)), s, c);
      checks++;
      if ({c, s} !== exp) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_op %0d a=%h b=%h cin=%0b got %0b_%h required %0b_%h",
                   n, a, b, ci, c, s, exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_basic();
    test_overflow();
    test_carry_in();
    test_back_to_back(1);
    repeat (4) @(negedge clk);
    test_back_to_back(3);
    repeat (4) @(negedge clk);
    test_reset_midop();
    repeat (4) @(negedge clk);
    test_ignore_beats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
